// File: rtl/axi_full_slave_mem_if.sv
// axi_full_slave_mem_if: AXI4 full write/read channel bundle between a master and the slave memory
interface axi_full_slave_mem_if #(parameter int ID_W = 3);
  logic [ID_W-1:0] awid;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid, awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready;
  logic [ID_W-1:0] bid;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [ID_W-1:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid, arready;
  logic [ID_W-1:0] rid;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_full_slave_mem.sv
// axi_full_slave_mem: AXI4 full slave over a word-addressed memory; one burst at a time, writes win ties
module axi_full_slave_mem #(
  parameter int DEPTH = 256,
  parameter int ID_W = 3
) (
  input logic s_axi_aclk,
  input logic s_axi_areset,
  axi_full_slave_mem_if.slave s_axi
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
  state_t r_state, w_next;
  logic [31:0] r_mem [DEPTH];
  logic [ID_W-1:0] r_id;
  logic [31:0] r_addr, w_mask, w_addr_nxt;
  logic [7:0] r_len, r_cnt;
  logic [1:0] r_burst;
  logic r_berr, r_werr;
  logic w_aw, w_ar, w_w, w_r, w_last, w_oor, w_we, w_rerr;
  logic [AW-1:0] w_idx;
  function automatic logic f_berr(input logic [2:0] size, input logic [1:0] burst,
                                  input logic [7:0] len, input logic [1:0] lsb);
    return size != 3'b010 || burst == 2'b11 ||
      (burst == 2'b10 && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || lsb != 2'b00));
  endfunction
  assign w_aw = s_axi.awvalid && s_axi.awready;
  assign w_ar = s_axi.arvalid && s_axi.arready;
  assign w_w = s_axi.wvalid && s_axi.wready;
  assign w_r = s_axi.rvalid && s_axi.rready;
  assign w_last = r_cnt == r_len;
  assign w_oor = {2'b00, r_addr[31:2]} >= 32'(DEPTH);
  assign w_idx = r_addr[AW+1:2];
  assign w_mask = (({24'b0, r_len} + 32'd1) << 2) - 32'd1;
  assign w_addr_nxt = r_burst == 2'b01 ? r_addr + 32'd4 :
                      r_burst == 2'b10 ? (r_addr & ~w_mask) | ((r_addr + 32'd4) & w_mask) : r_addr;
  assign w_we = w_w && !r_berr && !w_oor;
  assign w_rerr = r_berr || w_oor;
  assign s_axi.bid = s_axi.bvalid ? r_id : '0;
  assign s_axi.bresp = s_axi.bvalid && (r_berr || r_werr) ? 2'b10 : 2'b00;
  assign s_axi.rid = s_axi.rvalid ? r_id : '0;
  assign s_axi.rdata = s_axi.rvalid && !w_rerr ? r_mem[w_idx] : 32'd0;
  assign s_axi.rresp = s_axi.rvalid && w_rerr ? 2'b10 : 2'b00;
  assign s_axi.rlast = s_axi.rvalid && w_last;
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset)
    if (s_axi_areset) r_state <= IDLE;
    else r_state <= w_next;
  // ready outputs are held low while reset is asserted, even though the state already reads IDLE
  always_comb begin
    w_next = r_state;
    s_axi.awready = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.wready = 1'b0;
    s_axi.bvalid = 1'b0;
    s_axi.rvalid = 1'b0;
    case (r_state)
      IDLE: begin
        s_axi.awready = !s_axi_areset;
        s_axi.arready = !s_axi_areset && !s_axi.awvalid;
        w_next = w_aw ? WDATA : w_ar ? RDATA : IDLE;
      end
      WDATA: begin
        s_axi.wready = 1'b1;
        w_next = w_w && w_last ? WRESP : WDATA;
      end
      WRESP: begin
        s_axi.bvalid = 1'b1;
        w_next = s_axi.bready ? IDLE : WRESP;
      end
      default: begin
        s_axi.rvalid = 1'b1;
        w_next = w_r && w_last ? IDLE : RDATA;
      end
    endcase
  end
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset)
    if (s_axi_areset) begin
      r_id <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_burst <= '0;
      r_berr <= 1'b0;
      r_werr <= 1'b0;
    end else if (w_aw) begin
      r_id <= s_axi.awid;
      r_addr <= s_axi.awaddr;
      r_len <= s_axi.awlen;
      r_burst <= s_axi.awburst;
      r_cnt <= '0;
      r_berr <= f_berr(s_axi.awsize, s_axi.awburst, s_axi.awlen, s_axi.awaddr[1:0]);
      r_werr <= 1'b0;
    end else if (w_ar) begin
      r_id <= s_axi.arid;
      r_addr <= s_axi.araddr;
      r_len <= s_axi.arlen;
      r_burst <= s_axi.arburst;
      r_cnt <= '0;
      r_berr <= f_berr(s_axi.arsize, s_axi.arburst, s_axi.arlen, s_axi.araddr[1:0]);
    end else if (w_w || w_r) begin
      r_addr <= w_addr_nxt;
      r_cnt <= r_cnt + 8'd1;
      if (w_w && (s_axi.wlast != w_last || w_oor)) r_werr <= 1'b1;
    end
  always_ff @(posedge s_axi_aclk)
    for (int i = 0; i < 4; i++)
      if (w_we && s_axi.wstrb[i]) r_mem[w_idx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
endmodule

// File: tb/tb_axi_full_slave_mem.sv
// tb_axi_full_slave_mem: table vectors, corner sequences and random bursts checked against a memory model
module tb_axi_full_slave_mem;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] rd_q [256];
  logic [1:0] rr_q [256];
  axi_full_slave_mem_if #(.ID_W(3)) bus ();
  axi_full_slave_mem #(.DEPTH(DEPTH), .ID_W(3)) dut (
    .s_axi_aclk(clk),
    .s_axi_areset(rst),
    .s_axi(bus.slave)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic bit m_err(input logic [2:0] sz, input logic [1:0] bu, input logic [7:0] ln,
                               input logic [31:0] ad);
    if (sz != 3'd2 || bu == 2'd3) return 1'b1;
    if (bu == 2'd2) return !(ln == 1 || ln == 3 || ln == 7 || ln == 15) || ad % 4 != 0;
    return 1'b0;
  endfunction
  // address of beat i: wrap bursts cycle through the (len+1)*4-byte block holding the start address
  function automatic logic [31:0] m_addr(input logic [31:0] st, input logic [7:0] ln,
                                         input logic [1:0] bu, input int i);
    logic [31:0] tot, base;
    if (bu == 2'd0) return st;
    if (bu == 2'd1) return st + 32'(4 * i);
    tot = (32'(ln) + 32'd1) * 32'd4;
    base = st - st % tot;
    return base + (st - base + 32'(4 * i)) % tot;
  endfunction
  function automatic logic sel(input int w);
    return w == 0 ? bus.awready : w == 1 ? bus.wready : w == 2 ? bus.bvalid :
           w == 3 ? bus.arready : bus.rvalid;
  endfunction
  task automatic wait_hs(input int w, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (sel(w)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake timeout on channel %0d", w);
    end
  endtask
  task automatic aw_send(input logic [2:0] id, input logic [31:0] ad, input logic [7:0] ln,
                         input logic [2:0] sz, input logic [1:0] bu, output logic arr);
    bit ok;
    bus.awid = id; bus.awaddr = ad; bus.awlen = ln; bus.awsize = sz; bus.awburst = bu;
    bus.awvalid = 1'b1;
    wait_hs(0, ok);
    arr = bus.arready;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask
  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    bit ok;
    bus.wdata = d; bus.wstrb = s; bus.wlast = l; bus.wvalid = 1'b1;
    wait_hs(1, ok);
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
  endtask
  task automatic b_get(output logic [2:0] id, output logic [1:0] r);
    bit ok;
    bus.bready = 1'b1;
    wait_hs(2, ok);
    id = bus.bid;
    r = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask
  task automatic ar_send(input logic [2:0] id, input logic [31:0] ad, input logic [7:0] ln,
                         input logic [2:0] sz, input logic [1:0] bu);
    bit ok;
    bus.arid = id; bus.araddr = ad; bus.arlen = ln; bus.arsize = sz; bus.arburst = bu;
    bus.arvalid = 1'b1;
    wait_hs(3, ok);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask
  task automatic r_get(input bit tog, output logic [31:0] d, output logic [1:0] r,
                       output logic l, output logic [2:0] ri);
    logic [31:0] s;
    bit ok;
    bus.rready = !tog;
    wait_hs(4, ok);
    if (tog) begin
      s = bus.rdata;
      @(posedge clk); #1;
      bus.rready = 1'b1;
      @(negedge clk);
      chk("rdata_hold", bus.rdata, s);
    end
    d = bus.rdata; r = bus.rresp; l = bus.rlast; ri = bus.rid;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask
  task automatic txn_write(input logic [2:0] id, input logic [31:0] ad, input logic [7:0] ln,
                           input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] st,
                           input logic [31:0] d0, input int bad, input bit rnd,
                           output logic [1:0] br, output logic arr);
    logic [31:0] a, d;
    logic [2:0] bi;
    logic [1:0] eb;
    bit be;
    be = m_err(sz, bu, ln, ad);
    eb = be ? 2'b10 : 2'b00;
    aw_send(id, ad, ln, sz, bu, arr);
    for (int i = 0; i <= int'(ln); i++) begin
      d = rnd ? $urandom : d0 + 32'(i);
      if (i == bad) eb = 2'b10;
      if (!be) begin
        a = m_addr(ad, ln, bu, i);
        if ((a >> 2) >= 32'(DEPTH)) eb = 2'b10;
        else for (int b = 0; b < 4; b++) if (st[b]) m_mem[int'(a >> 2)][8*b +: 8] = d[8*b +: 8];
      end
      w_beat(d, st, (i == int'(ln)) != (i == bad));
    end
    b_get(bi, br);
    chk("bid", 32'(bi), 32'(id));
    chk("bresp", 32'(br), 32'(eb));
  endtask
  task automatic txn_read(input logic [2:0] id, input logic [31:0] ad, input logic [7:0] ln,
                          input logic [2:0] sz, input logic [1:0] bu, input bit tog);
    logic [31:0] a, ed, d;
    logic [1:0] er, r;
    logic l;
    logic [2:0] ri;
    bit be;
    be = m_err(sz, bu, ln, ad);
    ar_send(id, ad, ln, sz, bu);
    for (int i = 0; i <= int'(ln); i++) begin
      ed = 32'd0;
      er = 2'b10;
      if (!be) begin
        a = m_addr(ad, ln, bu, i);
        if ((a >> 2) < 32'(DEPTH)) begin
          ed = m_mem[int'(a >> 2)];
          er = 2'b00;
        end
      end
      r_get(tog, d, r, l, ri);
      rd_q[i] = d;
      rr_q[i] = r;
      chk("rdata", d, ed);
      chk("rresp", 32'(r), 32'(er));
      chk("rlast", 32'(l), 32'(i == int'(ln)));
      chk("rid", 32'(ri), 32'(id));
    end
  endtask
  typedef struct {
    logic [2:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
    logic [3:0] strb; logic [31:0] d0; int bad;
    logic [1:0] eb; logic [31:0] erd; logic [1:0] err;
  } vec_t;
  vec_t tv [12];
  logic [7:0] wrap_lens [4];
  initial begin
    logic [1:0] br, bu;
    logic arr;
    logic [7:0] ln;
    logic [2:0] sz;
    logic [31:0] ad;
    tv[0]  = '{3'd5, 32'h10,  8'd0, 3'd2, 2'd1, 4'hF, 32'hDEADBEEF, -1, 2'b00, 32'hDEADBEEF, 2'b00};
    tv[1]  = '{3'd1, 32'h40,  8'd0, 3'd2, 2'd1, 4'hF, 32'hFFFFFFFF, -1, 2'b00, 32'hFFFFFFFF, 2'b00};
    tv[2]  = '{3'd2, 32'h40,  8'd0, 3'd2, 2'd1, 4'h3, 32'h12345678, -1, 2'b00, 32'hFFFF5678, 2'b00};
    tv[3]  = '{3'd3, 32'h44,  8'd2, 3'd2, 2'd0, 4'hF, 32'd7,        -1, 2'b00, 32'd9,        2'b00};
    tv[4]  = '{3'd4, 32'h400, 8'd0, 3'd2, 2'd1, 4'hF, 32'h55,       -1, 2'b10, 32'd0,        2'b10};
    tv[5]  = '{3'd6, 32'h50,  8'd0, 3'd1, 2'd1, 4'hF, 32'h66,       -1, 2'b10, 32'd0,        2'b10};
    tv[6]  = '{3'd7, 32'h54,  8'd0, 3'd2, 2'd3, 4'hF, 32'h77,       -1, 2'b10, 32'd0,        2'b10};
    tv[7]  = '{3'd0, 32'h60,  8'd2, 3'd2, 2'd2, 4'hF, 32'h88,       -1, 2'b10, 32'd0,        2'b10};
    tv[8]  = '{3'd1, 32'h61,  8'd1, 3'd2, 2'd2, 4'hF, 32'h99,       -1, 2'b10, 32'd0,        2'b10};
    tv[9]  = '{3'd2, 32'h70,  8'd1, 3'd2, 2'd1, 4'hF, 32'hA0,        0, 2'b10, 32'hA1,       2'b00};
    tv[10] = '{3'd3, 32'h78,  8'd1, 3'd2, 2'd1, 4'hF, 32'hB0,        1, 2'b10, 32'hB1,       2'b00};
    tv[11] = '{3'd4, 32'h83,  8'd0, 3'd2, 2'd1, 4'hF, 32'hC0,       -1, 2'b00, 32'hC0,       2'b00};
    wrap_lens[0] = 8'd1; wrap_lens[1] = 8'd3; wrap_lens[2] = 8'd7; wrap_lens[3] = 8'd15;
    rst = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_rlast", 32'(bus.rlast), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_awready", 32'(bus.awready), 32'd1);
    // fill the whole memory with one maximum-length burst so the model starts fully known
    txn_write(3'd0, 32'h0, 8'd255, 3'd2, 2'd1, 4'hF, 32'd0, -1, 1'b1, br, arr);
    for (int v = 0; v < 12; v++) begin
      txn_write(tv[v].id, tv[v].addr, tv[v].len, tv[v].size, tv[v].burst, tv[v].strb,
                tv[v].d0, tv[v].bad, 1'b0, br, arr);
      chk($sformatf("vec%0d_bresp", v), 32'(br), 32'(tv[v].eb));
      txn_read(tv[v].id, tv[v].addr, tv[v].len, tv[v].size, tv[v].burst, 1'b0);
      chk($sformatf("vec%0d_rdata", v), rd_q[tv[v].len], tv[v].erd);
      chk($sformatf("vec%0d_rresp", v), 32'(rr_q[tv[v].len]), 32'(tv[v].err));
    end
    txn_write(3'd1, 32'h20, 8'd3, 3'd2, 2'd1, 4'hF, 32'd1, -1, 1'b0, br, arr);
    txn_read(3'd2, 32'h20, 8'd3, 3'd2, 2'd1, 1'b1);
    for (int i = 0; i < 4; i++) chk($sformatf("incr_beat%0d", i), rd_q[i], 32'(i + 1));
    txn_write(3'd3, 32'h38, 8'd3, 3'd2, 2'd2, 4'hF, 32'hA, -1, 1'b0, br, arr);
    txn_read(3'd4, 32'h30, 8'd3, 3'd2, 2'd1, 1'b0);
    chk("wrap_w30", rd_q[0], 32'hC);
    chk("wrap_w34", rd_q[1], 32'hD);
    chk("wrap_w38", rd_q[2], 32'hA);
    chk("wrap_w3c", rd_q[3], 32'hB);
    txn_read(3'd5, 32'h38, 8'd3, 3'd2, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_rd%0d", i), rd_q[i], 32'hA + 32'(i));
    txn_read(3'd6, 32'h3FC, 8'd1, 3'd2, 2'd1, 1'b0);
    chk("edge_resp0", 32'(rr_q[0]), 32'd0);
    chk("edge_resp1", 32'(rr_q[1]), 32'd2);
    chk("edge_data1", rd_q[1], 32'd0);
    bus.arid = 3'd6; bus.araddr = 32'h10; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'd1;
    bus.arvalid = 1'b1;
    txn_write(3'd1, 32'h10, 8'd0, 3'd2, 2'd1, 4'hF, 32'h5A5A0001, -1, 1'b0, br, arr);
    chk("prio_arready", 32'(arr), 32'd0);
    txn_read(3'd6, 32'h10, 8'd0, 3'd2, 2'd1, 1'b0);
    chk("prio_rdata", rd_q[0], 32'h5A5A0001);
    aw_send(3'd2, 32'h90, 8'd3, 3'd2, 2'd1, arr);
    w_beat(32'h111, 4'hF, 1'b0);
    w_beat(32'h222, 4'hF, 1'b0);
    m_mem[32'h90 >> 2] = 32'h111;
    m_mem[32'h94 >> 2] = 32'h222;
    bus.wdata = 32'h333; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wready", 32'(bus.wready), 32'd0);
    chk("mid_rst_awready", 32'(bus.awready), 32'd0);
    chk("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
    bus.wvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_bvalid", 32'(bus.bvalid), 32'd0);
    @(posedge clk); #1;
    txn_write(3'd5, 32'h98, 8'd0, 3'd2, 2'd1, 4'hF, 32'h444, -1, 1'b0, br, arr);
    chk("post_rst_bresp", 32'(br), 32'd0);
    txn_read(3'd5, 32'h90, 8'd3, 3'd2, 2'd1, 1'b0);
    for (int k = 0; k < 60; k++) begin
      bu = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      ln = bu == 2'd2 && $urandom_range(0, 4) != 0 ? wrap_lens[$urandom_range(0, 3)]
                                                     : 8'($urandom_range(0, 7));
      sz = $urandom_range(0, 9) == 0 ? 3'd1 : 3'd2;
      ad = 32'($urandom_range(0, 32'h41F));
      if ($urandom_range(0, 3) != 0) ad[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1)
        txn_write(3'($urandom), ad, ln, sz, bu, 4'($urandom), 32'd0,
                  $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 32'(ln))) : -1, 1'b1, br, arr);
      else
        txn_read(3'($urandom), ad, ln, sz, bu, 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
